mips_run_ctrl: RTL and testbench

//  Parametrised run controller for the MIPS core: sequences core reset, gates core clock-enable,

---
 rtl/mips_run_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mips_run_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
// Run controller for the MIPS core: sequences core reset, gates the core clock-enable,
// halts on PC breakpoints or a cycle budget, and tracks executed cycles and stores.
module mips_run_ctrl #(
    parameter int unsigned PC_W       = 32,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned NUM_BP     = 2,
    parameter int unsigned RST_CYCLES = 2,
    parameter int unsigned MAX_CYCLES = 1000,
    localparam int unsigned IDX_W     = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PC_W-1:0]        pc_current,
    input  logic                   we_dm,
    input  logic [31:0]            alu_out,
    input  logic [31:0]            wd_dm,
    input  logic [NUM_BP*PC_W-1:0] bp_addr,
    input  logic [NUM_BP-1:0]      bp_en,
    output logic                   core_rst,
    output logic                   core_clk_en,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             halt_reason,
    output logic [IDX_W-1:0]       halt_bp_idx,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [CNT_W-1:0]       store_cnt,
    output logic [31:0]            last_st_addr,
    output logic [31:0]            last_st_data
);

    localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    localparam logic [1:0] HALT_NONE = 2'b00;
    localparam logic [1:0] HALT_BP   = 2'b01;
    localparam logic [1:0] HALT_TO   = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [RC_W-1:0]  rst_cnt;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             timeout;
    logic             start_run;
    logic             rst_last;

    // Breakpoint match; scanning downward lets the lowest hitting index win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = int'(NUM_BP) - 1; i >= 0; i--) begin
            if (bp_en[i] && (pc_current == bp_addr[i*PC_W +: PC_W])) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign timeout   = (cycle_cnt == CNT_W'(MAX_CYCLES));
    assign start_run = start && ((state == IDLE) || (state == DONE));
    assign rst_last  = (rst_cnt == RC_W'(RST_CYCLES - 1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RESET;
            RESET:   if (rst_last) state_nxt = RUN;
            RUN:     if (hit || timeout) state_nxt = DONE;
            DONE:    if (start) state_nxt = RESET;
            default: state_nxt = IDLE;
        endcase
    end

    // Core-facing controls follow state directly so the core sees them in the same cycle.
    always_comb begin
        core_rst    = 1'b0;
        core_clk_en = 1'b0;
        if (rst || (state == RESET)) begin
            core_rst = 1'b1;
        end
        if ((state == RUN) && !hit && !timeout) begin
            core_clk_en = 1'b1;
        end
    end

    // Reset-hold counter, restarted every time RESET is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_cnt <= '0;
        end else if (state == RESET) begin
            rst_cnt <= rst_cnt + RC_W'(1);
        end else begin
            rst_cnt <= '0;
        end
    end

    // Status flags track the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == RESET) || (state_nxt == RUN);
            done <= (state_nxt == DONE);
        end
    end

    // Halt cause; breakpoint takes priority over timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_reason <= HALT_NONE;
            halt_bp_idx <= '0;
        end else if (start_run) begin
            halt_reason <= HALT_NONE;
            halt_bp_idx <= '0;
        end else if ((state == RUN) && hit) begin
            halt_reason <= HALT_BP;
            halt_bp_idx <= hit_idx;
        end else if ((state == RUN) && timeout) begin
            halt_reason <= HALT_TO;
        end
    end

    // Execution statistics; only cycles the core actually advances are counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt    <= '0;
            store_cnt    <= '0;
            last_st_addr <= '0;
            last_st_data <= '0;
        end else if (start_run) begin
            cycle_cnt    <= '0;
            store_cnt    <= '0;
            last_st_addr <= '0;
            last_st_data <= '0;
        end else if (core_clk_en) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (we_dm) begin
                store_cnt    <= store_cnt + CNT_W'(1);
                last_st_addr <= alu_out;
                last_st_data <= wd_dm;
            end
        end
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl with a toy core whose PC steps by 5 per executed cycle.
module tb_mips_run_ctrl;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned NUM_BP = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic [PC_W-1:0]        pc;
    logic                   we_dm;
    logic [31:0]            alu_out;
    logic [31:0]            wd_dm;
    logic [NUM_BP*PC_W-1:0] bp_addr;
    logic [NUM_BP-1:0]      bp_en;
    logic                   core_rst;
    logic                   core_clk_en;
    logic                   busy;
    logic                   done;
    logic [1:0]             halt_reason;
    logic [0:0]             halt_bp_idx;
    logic [CNT_W-1:0]       cycle_cnt;
    logic [CNT_W-1:0]       store_cnt;
    logic [31:0]            last_st_addr;
    logic [31:0]            last_st_data;

    logic loop_mode = 1'b0;
    logic we_force  = 1'b0;
    int   n_tests   = 0;
    int   n_fail    = 0;

    always #5 clk = ~clk;

    mips_run_ctrl #(
        .PC_W(PC_W), .CNT_W(CNT_W), .NUM_BP(NUM_BP), .RST_CYCLES(2), .MAX_CYCLES(20)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .pc_current(pc), .we_dm(we_dm),
        .alu_out(alu_out), .wd_dm(wd_dm), .bp_addr(bp_addr), .bp_en(bp_en),
        .core_rst(core_rst), .core_clk_en(core_clk_en), .busy(busy), .done(done),
        .halt_reason(halt_reason), .halt_bp_idx(halt_bp_idx), .cycle_cnt(cycle_cnt),
        .store_cnt(store_cnt), .last_st_addr(last_st_addr), .last_st_data(last_st_data)
    );

    // Toy core: PC advances by 5 when enabled, optionally looping in 0..25.
    always_ff @(posedge clk) begin
        if (core_rst) begin
            pc <= '0;
        end else if (core_clk_en) begin
            pc <= loop_mode ? ((pc + 32'd5) % 32'd30) : (pc + 32'd5);
        end
    end

    // Stores sit at PC 10, 20 and 30; the one at 30 writes 0x1234 to 0x54.
    assign we_dm   = we_force || (pc == 32'd10) || (pc == 32'd20) || (pc == 32'd30);
    assign alu_out = (pc == 32'd30) ? 32'h54 : pc;
    assign wd_dm   = (pc == 32'd30) ? 32'h1234 : pc * 32'd3;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    task automatic setup(input logic [31:0] bp0, input logic [31:0] bp1,
                         input logic [1:0] en, input logic lp);
        bp_addr   = {bp1, bp0};
        bp_en     = en;
        loop_mode = lp;
    endtask

    initial begin
        int n;
        setup(32'd50, 32'd0, 2'b01, 1'b0);
        repeat (2) @(negedge clk);
        check("rst_core_rst", 64'(core_rst), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        check("rst_halt", 64'(halt_reason), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_core_rst", 64'(core_rst), 64'd0);

        // Breakpoint at PC 50 after 10 executed cycles.
        pulse_start();
        n = 0;
        while (core_rst && n < 10) begin
            n++;
            @(negedge clk);
        end
        check("t1_rst_len", 64'(n), 64'd2);
        wait_done("t1_done");
        check("t1_halt", 64'(halt_reason), 64'd1);
        check("t1_idx", 64'(halt_bp_idx), 64'd0);
        check("t1_cycles", 64'(cycle_cnt), 64'd10);
        repeat (3) @(negedge clk);
        check("t1_pc_held", 64'(pc), 64'd50);
        check("t1_clk_en", 64'(core_clk_en), 64'd0);
        check("t1_core_rst", 64'(core_rst), 64'd0);
        check("t1_busy", 64'(busy), 64'd0);

        // Timeout with a looping program: 6 stores, last at PC 20.
        setup(32'd0, 32'd0, 2'b00, 1'b1);
        pulse_start();
        wait_done("t2_done");
        check("t2_halt", 64'(halt_reason), 64'd2);
        check("t2_cycles", 64'(cycle_cnt), 64'd20);
        check("t2_stores", 64'(store_cnt), 64'd6);
        check("t2_st_addr", 64'(last_st_addr), 64'h14);
        check("t2_st_data", 64'(last_st_data), 64'h3c);
        check("t2_clk_en", 64'(core_clk_en), 64'd0);

        // Restart from DONE clears results.
        pulse_start();
        check("rerun_busy", 64'(busy), 64'd1);
        check("rerun_done", 64'(done), 64'd0);
        check("rerun_cycles", 64'(cycle_cnt), 64'd0);
        check("rerun_stores", 64'(store_cnt), 64'd0);
        check("rerun_halt", 64'(halt_reason), 64'd0);
        wait_done("rerun_done2");
        check("rerun_cycles2", 64'(cycle_cnt), 64'd20);

        // Breakpoint priority.
        setup(32'd80, 32'd40, 2'b11, 1'b0);
        pulse_start();
        wait_done("t3a_done");
        check("t3a_idx", 64'(halt_bp_idx), 64'd1);
        check("t3a_cycles", 64'(cycle_cnt), 64'd8);
        setup(32'd40, 32'd40, 2'b11, 1'b0);
        pulse_start();
        wait_done("t3b_done");
        check("t3b_idx", 64'(halt_bp_idx), 64'd0);
        check("t3b_halt", 64'(halt_reason), 64'd1);

        // Three stores then breakpoint at 35; stores in DONE ignored.
        setup(32'd35, 32'd0, 2'b01, 1'b0);
        pulse_start();
        wait_done("t4_done");
        check("t4_cycles", 64'(cycle_cnt), 64'd7);
        check("t4_stores", 64'(store_cnt), 64'd3);
        check("t4_st_addr", 64'(last_st_addr), 64'h54);
        check("t4_st_data", 64'(last_st_data), 64'h1234);
        we_force = 1'b1;
        repeat (3) @(negedge clk);
        we_force = 1'b0;
        check("t4_stores_held", 64'(store_cnt), 64'd3);
        check("t4_cycles_held", 64'(cycle_cnt), 64'd7);

        // Breakpoint and timeout coincide at PC 100 / cycle 20.
        setup(32'd100, 32'd0, 2'b01, 1'b0);
        pulse_start();
        wait_done("t5_done");
        check("t5_halt", 64'(halt_reason), 64'd1);
        check("t5_cycles", 64'(cycle_cnt), 64'd20);

        // start during RUN is ignored; async rst mid-run clears at once.
        setup(32'd0, 32'd0, 2'b00, 1'b1);
        pulse_start();
        n = 0;
        while (cycle_cnt < 5 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t6_reached_run", 64'(cycle_cnt >= 5), 64'd1);
        pulse_start();
        check("t6_start_ignored_rst", 64'(core_rst), 64'd0);
        check("t6_start_ignored_busy", 64'(busy), 64'd1);
        check("t6_still_counting", 64'(cycle_cnt > 5), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_cycles", 64'(cycle_cnt), 64'd0);
        check("t6_stores", 64'(store_cnt), 64'd0);
        check("t6_core_rst", 64'(core_rst), 64'd1);
        check("t6_clk_en", 64'(core_clk_en), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_idle_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
